sram_bank_array: RTL and testbench

SRAM_BANK_ARRAY -- requirements
Module: sram_bank_array

---
 rtl/sram_bank_array.sv | 113 +++++++++++
 tb/tb_sram_bank_array.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_array.sv
// Parameterised grid of single-port SRAM banks: rows interleave addresses, columns slice the data word.
// Each bank has byte-enabled writes, a fixed-latency read pipeline, and a held read output.
module sram_bank_array #(
  parameter int SRAM_BANKS_ROWS      = 1,
  parameter int SRAM_BANKS_COLS      = 1,
  parameter int SRAM_BANK_ADDR_WIDTH = 16,
  parameter int SRAM_BANK_DATA_WIDTH = 32,
  parameter int SRAM_READ_LATENCY    = 2
) (
  input  logic                                                          clk_i,
  input  logic                                                          rst_i,
  input  logic [SRAM_BANK_ADDR_WIDTH-1:0]                               bank_addr,
  input  logic [SRAM_BANKS_ROWS*SRAM_BANKS_COLS-1:0]                    bank_cs,
  input  logic [SRAM_BANKS_ROWS*SRAM_BANKS_COLS-1:0]                    bank_we,
  input  logic [SRAM_BANKS_ROWS*SRAM_BANKS_COLS*(SRAM_BANK_DATA_WIDTH/8)-1:0] bank_be,
  input  logic [SRAM_BANKS_COLS*SRAM_BANK_DATA_WIDTH-1:0]               bank_wdata,
  output logic [SRAM_BANKS_ROWS*SRAM_BANKS_COLS*SRAM_BANK_DATA_WIDTH-1:0] bank_rdata,
  output logic                                                          multi_row_err_o,
  output logic [31:0]                                                   access_count_o
);

  localparam int NBANK = SRAM_BANKS_ROWS * SRAM_BANKS_COLS;
  localparam int DW    = SRAM_BANK_DATA_WIDTH;
  localparam int NBYTE = DW / 8;
  localparam int DEPTH = 1 << SRAM_BANK_ADDR_WIDTH;
  localparam int LAT   = SRAM_READ_LATENCY;

  logic        r_multi_err;
  logic [31:0] r_access_cnt;
  logic        w_multi;
  logic        w_seen;

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    localparam int COL = b % SRAM_BANKS_COLS;

    logic                    w_wr;
    logic                    w_rd;
    logic [DW-1:0]           w_rword;
    logic [LAT-1:0]          r_vld;
    logic [LAT-1:0][DW-1:0]  r_dat;
    logic [DW-1:0]           r_rdata;

    assign w_wr = bank_cs[b] & bank_we[b];
    assign w_rd = bank_cs[b] & ~bank_we[b];

    // One storage array per byte lane keeps byte-enable writes a plain per-lane write port.
    for (genvar k = 0; k < NBYTE; k++) begin : g_byte
      logic [7:0] r_mem [DEPTH];

      // NOTE: the storage array has no reset branch; its contents must survive reset and
      // a reset on a RAM would force it into flops.
      always_ff @(posedge clk_i) begin
        if (w_wr && bank_be[b*NBYTE+k]) begin
          r_mem[bank_addr] <= bank_wdata[COL*DW + k*8 +: 8];
        end
      end

      assign w_rword[k*8 +: 8] = r_mem[bank_addr];
    end

    // The word is captured at launch, so later writes to the same address cannot reach it.
    // NOTE: state registers use non-blocking assignments so every stage shifts on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_vld   <= '0;
        r_dat   <= '0;
        r_rdata <= '0;
      end else begin
        r_vld[0] <= w_rd;
        r_dat[0] <= w_rword;
        for (int s = 1; s < LAT; s++) begin
          r_vld[s] <= r_vld[s-1];
          r_dat[s] <= r_dat[s-1];
        end
        if (r_vld[LAT-1]) begin
          r_rdata <= r_dat[LAT-1];
        end
      end
    end

    assign bank_rdata[b*DW +: DW] = r_rdata;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch;
  // blocking assignments here let w_seen carry state across loop iterations.
  always_comb begin
    w_multi = 1'b0;
    w_seen  = 1'b0;
    for (int c = 0; c < SRAM_BANKS_COLS; c++) begin
      w_seen = 1'b0;
      for (int r = 0; r < SRAM_BANKS_ROWS; r++) begin
        if (bank_cs[r*SRAM_BANKS_COLS + c]) begin
          if (w_seen) w_multi = 1'b1;
          w_seen = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_multi_err  <= 1'b0;
      r_access_cnt <= '0;
    end else begin
      if (w_multi) r_multi_err <= 1'b1;
      if (|bank_cs) r_access_cnt <= r_access_cnt + 32'd1;
    end
  end

  assign multi_row_err_o = r_multi_err;
  assign access_count_o  = r_access_cnt;

endmodule

// File: tb/tb_sram_bank_array.sv
// Scoreboard bench for sram_bank_array: three instances (default, 2x2 grid, latency 1) driven from
// one request table, checked every cycle against a word-level memory model and a result queue.
module tb_sram_bank_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0]  d_addr; logic d_cs, d_we; logic [3:0] d_be; logic [31:0] d_wd, d_rd;
  logic         d_err;  logic [31:0] d_cnt;
  logic [7:0]   q_addr; logic [3:0] q_cs, q_we; logic [15:0] q_be; logic [63:0] q_wd;
  logic [127:0] q_rd;   logic q_err; logic [31:0] q_cnt;
  logic [7:0]   l_addr; logic l_cs, l_we; logic [3:0] l_be; logic [31:0] l_wd, l_rd;
  logic         l_err;  logic [31:0] l_cnt;

  sram_bank_array u_def (
    .clk_i(clk), .rst_i(rst), .bank_addr(d_addr), .bank_cs(d_cs), .bank_we(d_we),
    .bank_be(d_be), .bank_wdata(d_wd), .bank_rdata(d_rd),
    .multi_row_err_o(d_err), .access_count_o(d_cnt));

  sram_bank_array #(.SRAM_BANKS_ROWS(2), .SRAM_BANKS_COLS(2), .SRAM_BANK_ADDR_WIDTH(8)) u_quad (
    .clk_i(clk), .rst_i(rst), .bank_addr(q_addr), .bank_cs(q_cs), .bank_we(q_we),
    .bank_be(q_be), .bank_wdata(q_wd), .bank_rdata(q_rd),
    .multi_row_err_o(q_err), .access_count_o(q_cnt));

  sram_bank_array #(.SRAM_BANK_ADDR_WIDTH(8), .SRAM_READ_LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .bank_addr(l_addr), .bank_cs(l_cs), .bank_we(l_we),
    .bank_be(l_be), .bank_wdata(l_wd), .bank_rdata(l_rd),
    .multi_row_err_o(l_err), .access_count_o(l_cnt));

  // Generic request table: instance 0 = default, 1 = 2x2 grid, 2 = latency 1.
  logic        g_cs   [3][4];
  logic        g_we   [3][4];
  logic [3:0]  g_be   [3][4];
  logic [15:0] g_addr [3];
  logic [31:0] g_wd   [3][2];

  typedef struct {
    int          bank;
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mem_m [int];
  logic [31:0] exp_rd [3][4];
  logic [31:0] cnt_m [3];
  logic        err_m [3];
  rd_t         sb_q [3][$];
  rd_t         mon_e;
  int          cyc;
  int          n_checks;
  int          n_errors;

  function automatic int nb(input int i);   return (i == 1) ? 4 : 1; endfunction
  function automatic int cols(input int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int lat(input int i);  return (i == 2) ? 1 : 2; endfunction

  function automatic logic [31:0] rd_of(input int i, input int b);
    case (i)
      0:       return d_rd;
      1:       return q_rd[b*32 +: 32];
      default: return l_rd;
    endcase
  endfunction

  function automatic logic [31:0] cnt_of(input int i);
    case (i)
      0:       return d_cnt;
      1:       return q_cnt;
      default: return l_cnt;
    endcase
  endfunction

  function automatic logic err_of(input int i);
    case (i)
      0:       return d_err;
      1:       return q_err;
      default: return l_err;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    for (int i = 0; i < 3; i++) begin
      g_addr[i]  = '0;
      g_wd[i][0] = '0;
      g_wd[i][1] = '0;
      for (int b = 0; b < 4; b++) begin
        g_cs[i][b] = 1'b0;
        g_we[i][b] = 1'b0;
        g_be[i][b] = 4'h0;
      end
    end
  endtask

  task automatic req(input int i, input int b, input logic we, input logic [3:0] be);
    g_cs[i][b] = 1'b1;
    g_we[i][b] = we;
    g_be[i][b] = be;
  endtask

  task automatic apply();
    d_addr = g_addr[0]; d_cs = g_cs[0][0]; d_we = g_we[0][0]; d_be = g_be[0][0]; d_wd = g_wd[0][0];
    q_addr = g_addr[1][7:0]; q_wd = {g_wd[1][1], g_wd[1][0]};
    for (int b = 0; b < 4; b++) begin
      q_cs[b] = g_cs[1][b]; q_we[b] = g_we[1][b]; q_be[b*4 +: 4] = g_be[1][b];
    end
    l_addr = g_addr[2][7:0]; l_cs = g_cs[2][0]; l_we = g_we[2][0]; l_be = g_be[2][0]; l_wd = g_wd[2][0];
  endtask

  // Reference behaviour of one clock edge: word memory per bank, reads due lat() edges later.
  task automatic model_edge();
    int          key;
    int          rows_on;
    logic        any;
    logic [31:0] word;
    rd_t         e;
    for (int i = 0; i < 3; i++) begin
      any = 1'b0;
      for (int b = 0; b < nb(i); b++) begin
        if (g_cs[i][b]) begin
          any = 1'b1;
          key = i * 262144 + b * 65536 + int'(g_addr[i]);
          if (g_we[i][b]) begin
            word = mem_m.exists(key) ? mem_m[key] : 32'h0;
            for (int k = 0; k < 4; k++)
              if (g_be[i][b][k]) word[k*8 +: 8] = g_wd[i][b % cols(i)][k*8 +: 8];
            mem_m[key] = word;
          end else begin
            e.bank = b;
            e.due  = cyc + lat(i);
            e.data = mem_m[key];
            sb_q[i].push_back(e);
          end
        end
      end
      if (any) cnt_m[i] = cnt_m[i] + 32'd1;
      for (int c = 0; c < cols(i); c++) begin
        rows_on = 0;
        for (int r = 0; r < nb(i) / cols(i); r++)
          if (g_cs[i][r * cols(i) + c]) rows_on++;
        if (rows_on >= 2) err_m[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    apply();
    @(posedge clk);
    cyc++;
    if (!rst) model_edge();
    @(negedge clk);
    #1;
    clear_req();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb_q[i].delete();
      cnt_m[i] = '0;
      err_m[i] = 1'b0;
      for (int b = 0; b < 4; b++) exp_rd[i][b] = '0;
    end
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Monitor: retire results that fall due this cycle, then compare every observable output.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      while (sb_q[i].size() > 0 && sb_q[i][0].due == cyc) begin
        mon_e = sb_q[i].pop_front();
        exp_rd[i][mon_e.bank] = mon_e.data;
      end
      for (int b = 0; b < nb(i); b++)
        check($sformatf("rdata[%0d][%0d]@%0d", i, b, cyc), rd_of(i, b), exp_rd[i][b]);
      check($sformatf("count[%0d]@%0d", i, cyc), cnt_of(i), cnt_m[i]);
      check($sformatf("multi_err[%0d]@%0d", i, cyc), 32'(err_of(i)), 32'(err_m[i]));
    end
  end

  initial begin
    rst = 1'b0;
    cyc = 0;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 3; i++) begin
      cnt_m[i] = '0;
      err_m[i] = 1'b0;
      for (int b = 0; b < 4; b++) exp_rd[i][b] = '0;
    end
    clear_req();
    apply();
    #1;
    do_reset(2);

    // Read in flight when reset hits is dropped; memory keeps its contents.
    g_addr[0] = 16'h0040; g_wd[0][0] = 32'h1234_5678; req(0, 0, 1'b1, 4'hF); tick();
    g_addr[0] = 16'h0040; req(0, 0, 1'b0, 4'h0); tick();
    tick();
    do_reset(1);
    repeat (3) tick();
    g_addr[0] = 16'h0040; req(0, 0, 1'b0, 4'h0); tick();
    repeat (3) tick();

    // Byte-enable merge, read back at latency 2 with be ignored.
    g_addr[0] = 16'h0010; g_wd[0][0] = 32'hDEAD_BEEF; req(0, 0, 1'b1, 4'hF); tick();
    g_addr[0] = 16'h0010; g_wd[0][0] = 32'h0000_00AA; req(0, 0, 1'b1, 4'h1); tick();
    g_addr[0] = 16'h0010; req(0, 0, 1'b0, 4'hF); tick();
    repeat (3) tick();

    // Back-to-back reads stream one result per cycle.
    for (int a = 0; a < 8; a++) begin
      g_addr[0] = 16'(a); g_wd[0][0] = 32'(a * 3); req(0, 0, 1'b1, 4'hF); tick();
    end
    for (int a = 0; a < 8; a++) begin
      g_addr[0] = 16'(a); req(0, 0, 1'b0, 4'h0); tick();
    end
    repeat (3) tick();

    // 2x2 grid: single-bank write, then all four banks read at once (multi-row select).
    g_addr[1] = 16'h0005; g_wd[1][0] = 32'hA0A0_0000; g_wd[1][1] = 32'hA1A1_0001;
    req(1, 0, 1'b1, 4'hF); req(1, 1, 1'b1, 4'hF); tick();
    g_addr[1] = 16'h0005; g_wd[1][0] = 32'hB0B0_0010; g_wd[1][1] = 32'hB1B1_0011;
    req(1, 2, 1'b1, 4'hF); req(1, 3, 1'b1, 4'hF); tick();
    g_addr[1] = 16'h0005; g_wd[1][1] = 32'h1122_3344; req(1, 1, 1'b1, 4'hF); tick();
    g_addr[1] = 16'h0005;
    for (int b = 0; b < 4; b++) req(1, b, 1'b0, 4'h0);
    tick();
    repeat (3) tick();

    // Latency 1: read old, overwrite, read new; output holds in between.
    g_addr[2] = 16'h0021; g_wd[2][0] = 32'hCAFE_0001; req(2, 0, 1'b1, 4'hF); tick();
    g_addr[2] = 16'h0021; req(2, 0, 1'b0, 4'h0); tick();
    g_addr[2] = 16'h0021; g_wd[2][0] = 32'h0BAD_F00D; req(2, 0, 1'b1, 4'hF); tick();
    g_addr[2] = 16'h0021; req(2, 0, 1'b0, 4'h0); tick();
    repeat (3) tick();

    // Access counter wrap.
    #1;
    force u_def.r_access_cnt = 32'hFFFF_FFFF;
    #1;
    release u_def.r_access_cnt;
    cnt_m[0] = 32'hFFFF_FFFF;
    tick();
    g_addr[0] = 16'h0003; req(0, 0, 1'b0, 4'h0); tick();
    repeat (3) tick();

    // Fill addresses 0..15 of every bank so random reads hit defined data.
    for (int k = 0; k < 32; k++) begin
      if (k < 16) begin
        g_addr[0] = 16'(k); g_wd[0][0] = $urandom; req(0, 0, 1'b1, 4'hF);
        g_addr[2] = 16'(k); g_wd[2][0] = $urandom; req(2, 0, 1'b1, 4'hF);
      end
      g_addr[1] = 16'(k % 16); g_wd[1][0] = $urandom; g_wd[1][1] = $urandom;
      req(1, (k / 16) * 2, 1'b1, 4'hF); req(1, (k / 16) * 2 + 1, 1'b1, 4'hF);
      tick();
    end

    // Random traffic on all instances, with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset(2);
      for (int i = 0; i < 3; i++) begin
        g_addr[i]  = 16'($urandom_range(0, 15));
        g_wd[i][0] = $urandom;
        g_wd[i][1] = $urandom;
        for (int b = 0; b < nb(i); b++)
          if ($urandom_range(0, 3) != 0)
            req(i, b, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      tick();
    end

    repeat (4) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("sb_drain[%0d]", i), 32'(sb_q[i].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
